// File: rtl/target_timer_pkg.sv
// Shared timing constants for the special-move timers.
// Parents pick the 60 s pair or the short simulation pair.
package timer_pkg;

    localparam int TIMER_60S_WIDTH = 26;
    localparam logic [TIMER_60S_WIDTH-1:0] TIMER_60S_TARGET = 26'd46_875_000;

    localparam int TIMER_TEST_WIDTH = 5;
    localparam logic [TIMER_TEST_WIDTH-1:0] TIMER_TEST_TARGET = 5'd30;

endpackage

// File: rtl/target_timer_if.sv
// Control bundle between a parent FSM and one target timer.
// The parent drives target and enable, and reads back the hit level.
interface timer_if #(
    parameter int WIDTH = 26
);
    logic [WIDTH-1:0] target;
    logic             in;
    logic             hit_target;

    modport master (
        output target,
        output in,
        input  hit_target
    );

    modport slave (
        input  target,
        input  in,
        output hit_target
    );
endinterface

// File: rtl/target_timer.sv
// Saturating enabled-cycle counter with a run-time terminal count.
// The hit level depends only on the count register and the target.
module target_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = 26
) (
    input  logic   clk,
    input  logic   reset,
    timer_if.slave bus
);

    logic [WIDTH-1:0] count;
    logic             hit;

    // Comparing against the live target lets a lowered target hit at once.
    assign hit = (count >= bus.target);
    assign bus.hit_target = hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (bus.in && !hit) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_target_timer.sv
// Randomised bench for target_timer against an enabled-cycle model.
// Checks a 5-bit build in depth and a 26-bit build with short targets.
module tb_target_timer;
    import timer_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #10 clk = ~clk;

    timer_if #(.WIDTH(TIMER_TEST_WIDTH)) b5 ();
    timer_if #(.WIDTH(TIMER_60S_WIDTH))  b26 ();

    target_timer #(.WIDTH(TIMER_TEST_WIDTH)) dut5 (
        .clk   (clk),
        .reset (reset),
        .bus   (b5.slave)
    );

    target_timer #(.WIDTH(TIMER_60S_WIDTH)) dut26 (
        .clk   (clk),
        .reset (reset),
        .bus   (b26.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int mc     = 0;
    int mw     = 0;

    // One clock: apply inputs, advance the model at the edge, check mid-low.
    task automatic step(input logic e, input int t);
        b5.in     = e;
        b5.target = 5'(t);
        @(posedge clk);
        if (!reset && e && mc < t) mc++;
        @(negedge clk);
        n_chk++;
        if (b5.hit_target !== (mc >= t))
            $display("FAIL hit5 t=%0d got %b want %b",
                     t, b5.hit_target, (mc >= t));
        else n_pass++;
        n_chk++;
        if (dut5.count !== 5'(mc))
            $display("FAIL count5 got %0d want %0d", dut5.count, mc);
        else n_pass++;
    endtask

    task automatic hard_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        mc = 0;
        mw = 0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        b5.target = 5'd30;
        b5.in     = 1'b0;
        #1;
        n_chk++;
        if (b5.hit_target !== 1'b0 || dut5.count !== 5'd0)
            $display("FAIL reset_state got hit=%b cnt=%0d want 0/0",
                     b5.hit_target, dut5.count);
        else n_pass++;
        b5.target = 5'd0;
        #1;
        n_chk++;
        if (b5.hit_target !== 1'b1)
            $display("FAIL reset_t0 got %b want 1", b5.hit_target);
        else n_pass++;
        b5.target = 5'd30;
        @(negedge clk);
        reset = 1'b0;
        mc = 0;
        mw = 0;
        repeat (100) step(1'b0, 30);
    endtask

    task automatic test_count();
        repeat (30) step(1'b1, 30);
        repeat (100) step(1'b1, 30);
    endtask

    task automatic test_pause();
        hard_reset();
        repeat (10) step(1'b1, 30);
        repeat (20) step(1'b0, 30);
        n_chk++;
        if (dut5.count !== 5'd10)
            $display("FAIL pause_freeze got %0d want 10", dut5.count);
        else n_pass++;
        repeat (25) step(1'b1, 30);
    endtask

    task automatic test_async_reset();
        hard_reset();
        repeat (17) step(1'b1, 30);
        #3;
        reset = 1'b1;
        #1;
        n_chk++;
        if (dut5.count !== 5'd0 || b5.hit_target !== 1'b0)
            $display("FAIL async_reset got cnt=%0d hit=%b want 0/0",
                     dut5.count, b5.hit_target);
        else n_pass++;
        b5.target = 5'd0;
        #1;
        n_chk++;
        if (b5.hit_target !== 1'b1)
            $display("FAIL async_reset_t0 got %b want 1", b5.hit_target);
        else n_pass++;
        mc = 0;
        mw = 0;
        #2;
        reset = 1'b0;
        repeat (3) step(1'b1, 0);
        repeat (35) step(1'b1, 30);
    endtask

    task automatic test_retarget();
        hard_reset();
        repeat (20) step(1'b1, 30);
        repeat (3) step(1'b1, 15);
        b5.target = 5'd25;
        #1;
        n_chk++;
        if (b5.hit_target !== 1'b0)
            $display("FAIL retarget_unhit got %b want 0", b5.hit_target);
        else n_pass++;
        repeat (10) step(1'b1, 25);
    endtask

    task automatic test_saturate();
        hard_reset();
        repeat (81) step(1'b1, 31);
        n_chk++;
        if (dut5.count !== 5'd31)
            $display("FAIL saturate31 got %0d want 31", dut5.count);
        else n_pass++;
    endtask

    task automatic test_random();
        int t;
        hard_reset();
        t = 30;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) t = $urandom_range(0, 31);
            if ($urandom_range(0, 59) == 0) hard_reset();
            step(1'(($urandom % 4) != 0), t);
        end
    endtask

    task automatic test_wide();
        int   tw;
        logic e;
        hard_reset();
        tw         = $urandom_range(1000, 3000);
        b26.target = 26'(tw);
        for (int i = 0; i < 5000; i++) begin
            e      = 1'(($urandom % 4) != 0);
            b26.in = e;
            @(posedge clk);
            if (e && mw < tw) mw++;
            @(negedge clk);
            n_chk++;
            if (b26.hit_target !== (mw >= tw) || dut26.count !== 26'(mw))
                $display("FAIL wide t=%0d got hit=%b cnt=%0d want %b/%0d",
                         tw, b26.hit_target, dut26.count, (mw >= tw), mw);
            else n_pass++;
        end
        b26.in = 1'b0;
    endtask

    initial begin
        b26.in     = 1'b0;
        b26.target = 26'd1;
        test_reset();
        test_count();
        test_pause();
        test_async_reset();
        test_retarget();
        test_saturate();
        test_random();
        test_wide();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
